// File: rtl/fifo_byte_unpacker_if.sv
// fifo_byte_unpacker_if: handshake/bus bundle between the SCSI-DMA longword
// FIFO read side, the byte unpacker and the SCSI state machine.
interface fifo_byte_unpacker_if;
   logic        ENABLE;
   logic [31:0] FIFO_OD;
   logic        FIFOEMPTY;
   logic        LOAD_BO;
   logic [1:0]  BO_INIT;
   logic [7:0]  PD;
   logic        PD_VALID;
   logic        PD_ACK;
   logic        INCBO;
   logic        INCNO;
   logic        DECFIFO;
   logic [1:0]  BO;
   logic        BUSY;

   // unpacker side
   modport slave (
      input  ENABLE, FIFO_OD, FIFOEMPTY, LOAD_BO, BO_INIT, PD_ACK,
      output PD, PD_VALID, INCBO, INCNO, DECFIFO, BO, BUSY
   );

   // FIFO core / SCSI engine side
   modport master (
      output ENABLE, FIFO_OD, FIFOEMPTY, LOAD_BO, BO_INIT, PD_ACK,
      input  PD, PD_VALID, INCBO, INCNO, DECFIFO, BO, BUSY
   );
endinterface

// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker: pulls 32-bit entries from the SCSI-DMA FIFO and hands
// them to the SCSI side one byte at a time (memory->SCSI direction).
// Optional macro FIFO_RD_PREFETCH_EN: retire each longword in its first SEND
// cycle and chain straight into the next one, removing inter-longword bubbles.
module fifo_byte_unpacker #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input logic                  CLK,
   input logic                  RST,
   fifo_byte_unpacker_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_SEND   = 2'd2,
      S_RETIRE = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_hold;
   logic [1:0]  r_bo;
   logic        r_incbo;
   logic        r_incno;

   logic [1:0]  w_sel;
   logic [7:0]  w_pd;

   // byte lane picked by the pointer; 68k order puts pointer 0 on the MSB
   always_comb begin
      w_sel = BIG_ENDIAN ? (2'd3 - r_bo) : r_bo;
      case (w_sel)
         2'd0:    w_pd = r_hold[7:0];
         2'd1:    w_pd = r_hold[15:8];
         2'd2:    w_pd = r_hold[23:16];
         default: w_pd = r_hold[31:24];
      endcase
   end

   // fetch / send / retire sequencing; strobes are one-cycle registered pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_hold  <= 32'h0;
         r_bo    <= 2'd0;
         r_incbo <= 1'b0;
         r_incno <= 1'b0;
      end else begin
         r_incbo <= 1'b0;
         r_incno <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.LOAD_BO)
                  r_bo <= bus.BO_INIT;
               else if (bus.ENABLE && !bus.FIFOEMPTY)
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_hold  <= bus.FIFO_OD;
               r_state <= S_SEND;
`ifdef FIFO_RD_PREFETCH_EN
               // retire early so FIFO_OD shows the next entry by the last byte
               r_incno <= 1'b1;
`endif
            end
            S_SEND: begin
               if (bus.PD_ACK) begin
                  r_incbo <= 1'b1;
                  if (r_bo != 2'd3) begin
                     r_bo <= r_bo + 2'd1;
                  end else begin
                     r_bo <= 2'd0;
`ifdef FIFO_RD_PREFETCH_EN
                     // r_incno high means the pop of the held entry has not
                     // landed yet, so FIFO_OD still shows it: do not chain
                     if (bus.ENABLE && !bus.FIFOEMPTY && !r_incno) begin
                        r_hold  <= bus.FIFO_OD;
                        r_incno <= 1'b1;
                     end else begin
                        r_state <= S_IDLE;
                     end
`else
                     r_state <= S_RETIRE;
                     r_incno <= 1'b1;
`endif
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.PD       = w_pd;
   assign bus.PD_VALID = (r_state == S_SEND);
   assign bus.INCBO    = r_incbo;
   assign bus.INCNO    = r_incno;
   assign bus.DECFIFO  = r_incno;
   assign bus.BO       = r_bo;
   assign bus.BUSY     = (r_state != S_IDLE);

endmodule
